// File: rtl/tgl_decoder.sv
// tgl_decoder: recovers events from a toggle line (one flip per event).
// Synchronises t_in, detects level changes, queues them in a saturating
// pending counter drained by ev_valid/ev_ack, with a sticky overflow flag.
// Ports: clk (state on falling edge), clr_n (async active-low reset),
//   t_in (async toggle), en, ev_ack, ovf_clr -> level, ev_pulse, ev_valid,
//   pending[CNT_W], ovf, total[TOT_W].
// Macro TGL_DEC_TOTAL_EN: builds the wrapping total counter; else total=0.
module tgl_decoder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned TOT_W       = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             t_in,
   input  logic             en,
   input  logic             ev_ack,
   input  logic             ovf_clr,
   output logic             level,
   output logic             ev_pulse,
   output logic             ev_valid,
   output logic [CNT_W-1:0] pending,
   output logic             ovf,
   output logic [TOT_W-1:0] total
);

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   // last INIT edge index: INIT spans SYNC_STAGES+1 edges
   localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q;
   logic [0:0]             state_q, state_d;
   logic [2:0]             icnt_q, icnt_d;
   logic                   pulse_q;
   logic [CNT_W-1:0]       pend_q, pend_d;
   logic                   ovf_q, ovf_d;
   logic                   accept;
   logic                   ack_eff;
   logic                   lost;

   assign sync_d   = {sync_q[SYNC_STAGES-2:0], t_in};
   assign level    = sync_q[SYNC_STAGES-1];
   assign ev_valid = |pend_q;
   assign ack_eff  = ev_ack & ev_valid;
   assign accept   = (state_q == S_RUN) & en & (level != prev_q);

   always_comb begin
      state_d = state_q;
      icnt_d  = icnt_q;
      if (state_q == S_INIT) begin
         icnt_d = icnt_q + 3'd1;
         if (icnt_q == INIT_LAST) begin
            state_d = S_RUN;
            icnt_d  = '0;
         end
      end
   end

   // accept together with an effective ack cancels out, even at max
   always_comb begin
      pend_d = pend_q;
      lost   = 1'b0;
      unique case ({accept, ack_eff})
         2'b10: begin
            if (pend_q == PEND_MAX) lost = 1'b1;
            else pend_d = pend_q + 1'b1;
         end
         2'b01:   pend_d = pend_q - 1'b1;
         default: pend_d = pend_q;
      endcase
   end

   // a loss on the same edge as ovf_clr keeps the flag set
   assign ovf_d = lost | (ovf_q & ~ovf_clr);

   always_ff @(negedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         state_q <= S_INIT;
         icnt_q  <= '0;
         pulse_q <= 1'b0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= level;
         state_q <= state_d;
         icnt_q  <= icnt_d;
         pulse_q <= accept;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ev_pulse = pulse_q;
   assign pending  = pend_q;
   assign ovf      = ovf_q;

`ifdef TGL_DEC_TOTAL_EN
   logic [TOT_W-1:0] tot_q;

   always_ff @(negedge clk or negedge clr_n) begin
      if (!clr_n) tot_q <= '0;
      else if (accept) tot_q <= tot_q + 1'b1;
   end

   assign total = tot_q;
`else
   assign total = '0;
`endif

endmodule

// File: doc/tgl_decoder.md
# tgl_decoder

Receive-side counterpart of the team's toggle flip-flop event signalling. A sender flips a single line `t_in` once per event, and this block recovers the events. It synchronises `t_in` into the local `clk` domain and detects each level change, turning it into a one-cycle pulse. It also queues the detected events in a saturating pending counter, which a consumer drains through a valid/ack handshake. An overflow flag is sticky, and an optional wrapping event total is provided.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchroniser flops on `t_in`; legal range 2–4.
- `CNT_W`, default 4: width of the pending-event counter; it saturates at 2^CNT_W−1.
- `TOT_W`, default 8: width of the total-event counter.

Ports:
- `clk` in 1: single clock; all state updates on the falling edge.
- `clr_n` in 1: reset, asynchronous, active-low.
- `t_in` in 1: toggle line from the sender; asynchronous to `clk`.
- `en` in 1: decode enable; while low, toggles are tracked but neither counted nor pulsed.
- `ev_ack` in 1: consumer takes one pending event when `ev_valid` is high.
- `ovf_clr` in 1: clears `ovf`.
- `level` out 1: synchronised `t_in` (last sync stage).
- `ev_pulse` out 1: one-cycle registered pulse per accepted toggle.
- `ev_valid` out 1: high while `pending` ≠ 0.
- `pending` out CNT_W: number of queued events.
- `ovf` out 1: sticky; set when an event is lost.
- `total` out TOT_W: wrapping count of accepted events.

## Operation
- Sync chain: `t_in` → s[0] → … → s[SYNC_STAGES−1] = `level`. Register `prev` holds `level` from the previous edge. A toggle is detected when `level` ≠ `prev`.
- Control states:
  - INIT: entered on reset. For SYNC_STAGES+1 edges after `clr_n` deasserts, `prev` follows `level` and no toggle is detected. This prevents a static-high `t_in` at reset release from creating a false event. The block then moves to RUN.
  - RUN: a toggle is accepted when `en`=1. `prev` updates every edge regardless of `en`.
- An accepted toggle drives all of the following at the same edge:
  - `ev_pulse`=1 for one cycle;
  - `total` increments, wrapping from 2^TOT_W−1 to 0;
  - `pending` is updated per the rules below.
- `pending` update rules (`ack_eff` = `ev_ack` & `ev_valid`):
  - accept only, below max: +1.
  - `ack_eff` only: −1.
  - accept and `ack_eff`: unchanged, at any value including max.
  - accept at max without `ack_eff`: unchanged and `ovf` set.
  - `ev_ack` while `pending`=0: ignored.
- `ovf`: cleared by `ovf_clr`; a set condition on the same edge wins.
- Reset values:
  - sync flops, `prev`, `ev_pulse`, `pending`, `total`, `ovf` all 0;
  - state is INIT;
  - `ev_valid`=0 and `level`=0.
- Asserting `clr_n` mid-operation discards queued events immediately (asynchronous), and the block re-enters INIT.

## Timing
- Latency: a `t_in` change that meets setup before falling edge 1 appears on `level` at edge SYNC_STAGES. `ev_pulse`, `pending`, and `ev_valid` update at edge SYNC_STAGES+1; with the default, that is 3 edges.
- `ev_valid` is a combinational decode of registered `pending`. An ack sampled at edge N is reflected in `pending` after edge N.
- The sender must hold each `t_in` level for at least 2 `clk` periods. Two flips inside one period may cancel, and that loss is not flagged.
- `en` is sampled on the same edge as the detection compare.

## Configuration
- `TGL_DEC_TOTAL_EN`:
  - Defined: the `total` counter is implemented as described.
  - Undefined: no counter flops are built, and `total` is tied to 0. Every other behaviour is identical.

## Test plan
- Reset with `t_in`=1 held, release `clr_n`, `en`=1 → no `ev_pulse` and `pending`=0 after 10 cycles; `level`=1 from edge 2.
- Four `t_in` flips spaced 4 cycles apart, no ack → four single-cycle `ev_pulse`s, each 3 edges after its flip; `pending`=4; `total`=4 (macro defined) or 0 (undefined).
- With `pending`=3, hold `ev_ack`=1 for 5 cycles with no toggles → `pending` goes 2,1,0; `ev_valid` falls after the third ack edge; the extra acks are ignored.
- CNT_W=2: fill to `pending`=3, then one more toggle → `ovf`=1, `pending`=3. Toggle and ack on the same edge → `pending`=3 and no further overflow. Pulse `ovf_clr` → `ovf`=0.
- `en`=0 during two flips, then `en`=1 and flip once more → exactly one event; `pending`=1.
- With `pending`=5 and `total`=0xFF, assert `clr_n`=0 asynchronously between edges → all outputs drop to 0 at once; after release, the block waits 3 edges in INIT before accepting new toggles.
